// File: rtl/program_loader_if.sv
// ============================================================================
// Module      : program_loader_if
// Description : Byte-stream input and instruction-memory write port bundle
//               for program_loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface program_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [7:0]            iData;
  logic                  iValid;
  logic                  oReady;
  logic                  oWriteEnable;
  logic [ADDR_WIDTH-1:0] oWriteAddress;
  logic [27:0]           oInstruction;
  logic                  oCpuHold;
  logic                  oDone;
  logic                  oError;

  // Host side: stream source and consumer of the memory write port / status.
  modport master (
    output iData, iValid,
    input  oReady, oWriteEnable, oWriteAddress, oInstruction,
    input  oCpuHold, oDone, oError
  );

  modport slave (
    input  iData, iValid,
    output oReady, oWriteEnable, oWriteAddress, oInstruction,
    output oCpuHold, oDone, oError
  );
endinterface

`default_nettype wire

// File: rtl/program_loader.sv
// ============================================================================
// Module      : program_loader
// Description : Framed byte-stream loader writing 28-bit words into CPU
//               instruction memory; optional trailing XOR checksum enabled
//               by defining LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module program_loader #(
  parameter int         ADDR_WIDTH     = 8,
  parameter int         MAX_WORDS      = 255,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  program_loader_if.slave bus
);

  localparam int c_CW = ((ADDR_WIDTH > 8) ? ADDR_WIDTH : 8) + 1;
  localparam int c_TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [c_TW-1:0] c_TIMER_LAST =
    c_TW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COUNT   = 2'd1,
    S_PAYLOAD = 2'd2
`ifdef LOADER_CHECKSUM_EN
    , S_CHECK = 2'd3
`endif
  } state_t;

  state_t                r_state,   w_state;
  logic                  r_ready;
  logic                  r_we,      w_we;
  logic [ADDR_WIDTH-1:0] r_waddr,   w_waddr;
  logic [27:0]           r_instr,   w_instr;
  logic                  r_hold,    w_hold;
  logic                  r_done,    w_done;
  logic                  r_error,   w_error;
  logic [7:0]            r_count,   w_count;
  logic [ADDR_WIDTH-1:0] r_addr,    w_addr;
  logic [1:0]            r_byteIdx, w_byteIdx;
  logic [19:0]           r_word,    w_word;
  logic [c_TW-1:0]       r_timer,   w_timer;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            r_csum,    w_csum;
`endif

  logic w_accept;
  logic w_lastWord;

  assign w_accept   = bus.iValid & r_ready;
  assign w_lastWord = ((c_CW'(r_addr) + c_CW'(1)) == c_CW'(r_count));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ready   <= 1'b0;
      r_we      <= 1'b0;
      r_waddr   <= '0;
      r_instr   <= '0;
      r_hold    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_count   <= '0;
      r_addr    <= '0;
      r_byteIdx <= '0;
      r_word    <= '0;
      r_timer   <= '0;
`ifdef LOADER_CHECKSUM_EN
      r_csum    <= '0;
`endif
    end else begin
      r_state   <= w_state;
      r_ready   <= 1'b1;
      r_we      <= w_we;
      r_waddr   <= w_waddr;
      r_instr   <= w_instr;
      r_hold    <= w_hold;
      r_done    <= w_done;
      r_error   <= w_error;
      r_count   <= w_count;
      r_addr    <= w_addr;
      r_byteIdx <= w_byteIdx;
      r_word    <= w_word;
      r_timer   <= w_timer;
`ifdef LOADER_CHECKSUM_EN
      r_csum    <= w_csum;
`endif
    end
  end

  always_comb begin
    w_state   = r_state;
    w_we      = 1'b0;
    w_waddr   = r_waddr;
    w_instr   = r_instr;
    w_hold    = r_hold;
    w_done    = r_done;
    w_error   = r_error;
    w_count   = r_count;
    w_addr    = r_addr;
    w_byteIdx = r_byteIdx;
    w_word    = r_word;
    w_timer   = r_timer;
`ifdef LOADER_CHECKSUM_EN
    w_csum    = r_csum;
`endif

    if ((r_state != S_IDLE) && !w_accept) begin
      // Inter-byte stall inside a frame: abort once the idle budget is spent.
      if (TIMEOUT_CYCLES != 0) begin
        if (r_timer == c_TIMER_LAST) begin
          w_state   = S_IDLE;
          w_error   = 1'b1;
          w_done    = 1'b0;
          w_byteIdx = '0;
          w_timer   = '0;
        end else begin
          w_timer = r_timer + c_TW'(1);
        end
      end
    end else if (w_accept) begin
      w_timer = '0;
      case (r_state)
        S_IDLE: begin
          if (bus.iData == SYNC_BYTE) begin
            w_state   = S_COUNT;
            w_hold    = 1'b1;
            w_done    = 1'b0;
            w_error   = 1'b0;
            w_addr    = '0;
            w_byteIdx = '0;
`ifdef LOADER_CHECKSUM_EN
            w_csum    = '0;
`endif
          end
        end
        S_COUNT: begin
          if ((bus.iData == 8'd0) || (32'(bus.iData) > 32'(MAX_WORDS))) begin
            w_state = S_IDLE;
            w_error = 1'b1;
          end else begin
            w_count = bus.iData;
            w_state = S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
`ifdef LOADER_CHECKSUM_EN
          w_csum    = r_csum ^ bus.iData;
`endif
          // Only 20 bits are kept so byte 0's upper nibble falls off the top.
          w_word    = {r_word[11:0], bus.iData};
          w_byteIdx = r_byteIdx + 2'd1;
          if (r_byteIdx == 2'd3) begin
            w_we    = 1'b1;
            w_waddr = r_addr;
            w_instr = {r_word, bus.iData};
            w_addr  = r_addr + ADDR_WIDTH'(1);
            if (w_lastWord) begin
`ifdef LOADER_CHECKSUM_EN
              w_state = S_CHECK;
`else
              w_state = S_IDLE;
              w_done  = 1'b1;
              w_hold  = 1'b0;
`endif
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHECK: begin
          w_state = S_IDLE;
          if (bus.iData == r_csum) begin
            w_done = 1'b1;
            w_hold = 1'b0;
          end else begin
            w_error = 1'b1;
          end
        end
`endif
        default: w_state = S_IDLE;
      endcase
    end
  end

  assign bus.oReady        = r_ready;
  assign bus.oWriteEnable  = r_we;
  assign bus.oWriteAddress = r_waddr;
  assign bus.oInstruction  = r_instr;
  assign bus.oCpuHold      = r_hold;
  assign bus.oDone         = r_done;
  assign bus.oError        = r_error;

endmodule

`default_nettype wire
